embcpu_pio_ext: RTL and testbench
=================================

EMBCPU_PIO_EXT -- requirements
Module: embcpu_pio_ext

Interface
REQ-001 Parameter WIDTH, default 8: PIO bit count, legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 0: out_port value after reset.
REQ-003 Parameter DIR_RESET, default all ones: direction value after reset; bit=1 means output.
REQ-004 Parameter EDGE_TYPE, default 0: edge to capture; 0 rising, 1 falling, 2 any.
REQ-005 Parameter SYNC_STAGES, default 2: in_port synchroniser depth, legal range 2..3.
REQ-006 Ports SHALL be:
- clk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  Avalon-MM word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  read data; bits above WIDTH read 0.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  output data register.
- oe_port  out  WIDTH  direction register; 1 = drive.
- irq  out  1  level interrupt, active high.

Function
REQ-007 Write strobe SHALL be chipselect && !write_n; register updates occur at the next clk rising edge, zero wait states.
REQ-008 readdata SHALL be combinational from address and register state, zero-latency, ungated by chipselect.
REQ-009 Map:
- 0 data: write loads out_port; read = (out_port & oe_port) | (sync_in & ~oe_port).
- 1 direction: R/W.
- 2 irq mask: R/W, reset 0.
- 3 edge capture: read; write-one-to-clear.
- 4 outset: out_port |= wd.
- 5 outclear: out_port &= ~wd.
- 6 outtoggle: out_port ^= wd.
- 7 reserved.
- Registers 4-7 read 0; writes to 7 ignored.
REQ-010 in_port SHALL pass through SYNC_STAGES flops, then one history flop; a change on the pin is visible in data reads after SYNC_STAGES edges.
REQ-011 An edge per EDGE_TYPE between sync_in and history SHALL set the capture bit one edge later, only for bits with oe_port=0.
REQ-012 Capture bits SHALL hold until cleared; a clearing write and a new edge on the same bit in the same cycle SHALL leave the bit set.
REQ-013 irq SHALL equal |(edge_capture & irq_mask), combinational from registers.
REQ-014 Changing a bit from output to input SHALL NOT itself set capture; history tracks sync_in regardless of direction.

Reset
REQ-015 On reset_n low, immediately and regardless of clk: out_port=RESET_VALUE, oe_port=DIR_RESET, mask=0, capture=0, synchroniser and history flops=0, irq=0.
REQ-016 Reset asserted mid-write SHALL discard the write; the first edge after deassertion SHALL NOT set capture.

Configuration
REQ-017 Macro EMBCPU_PIO_EXT_IRQ_EN defined: mask, capture, history and irq logic present as above.
REQ-018 Without it: those registers are absent; addresses 2-3 read 0 and ignore writes; irq tied 0. The data path and synchroniser are unchanged.

Structure
REQ-019 Package embcpu_pio_pkg SHALL hold address constants ADDR_DATA..ADDR_TOGGLE and the edge-type encoding constants.
REQ-020 The synchroniser plus history flop and edge detector SHALL be sub-module embcpu_pio_sync, parametrised by WIDTH, SYNC_STAGES and EDGE_TYPE, outputting sync_in and edge pulse vectors.

Verification (WIDTH=8, defaults unless stated)
REQ-021 Bench SHALL cover:
- Reset, then write 0xA5 to addr 0: out_port=0xA5 one edge later; read addr 0 = 0xA5.
- From 0xA5, write 0x0F to addr 4, then 0x81 to addr 5, then 0xFF to addr 6: out_port sequence 0xAF, 0x2E, 0xD1.
- Dir=0x00, in_port 0->0x01: read addr 0 = 0x01 after 2 edges; capture bit0 set after 3 edges; mask=0x01 -> irq=1; W1C 0x01 -> irq=0.
- Rising edge on bit0 in the same cycle as a W1C of 0x01 to addr 3: capture bit0 remains 1.
- Dir=0x0F, in_port=0x3C, out_port=0x55: read addr 0 = 0x35; edges on bits 0-3 never set capture.
- Build without EMBCPU_PIO_EXT_IRQ_EN: addrs 2-3 read 0 after writes of 0xFF; irq stays 0 under input toggling.

Source files
------------

// File: rtl/embcpu_pio_pkg.sv
// Shared constants for the embcpu PIO block: register word addresses and edge-type encoding.
package embcpu_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_SET      = 3'd4;
    localparam logic [2:0] ADDR_CLEAR    = 3'd5;
    localparam logic [2:0] ADDR_TOGGLE   = 3'd6;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/embcpu_pio_sync.sv
// Pin synchroniser with history flop and edge detector.
// History and edge detection exist only when EMBCPU_PIO_EXT_IRQ_EN is defined.
module embcpu_pio_sync
    import embcpu_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign sync_in = r_sync[SYNC_STAGES-1];

`ifdef EMBCPU_PIO_EXT_IRQ_EN
    // History follows sync_in for every bit, so a direction change never looks like an edge.
    logic [WIDTH-1:0] r_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_hist <= '0;
        else          r_hist <= sync_in;
    end

    always_comb begin
        edge_pulse = sync_in & ~r_hist;
        if (EDGE_TYPE == EDGE_FALL)     edge_pulse = ~sync_in & r_hist;
        else if (EDGE_TYPE == EDGE_ANY) edge_pulse = sync_in ^ r_hist;
    end
`else
    assign edge_pulse = '0;
`endif

endmodule

// File: rtl/embcpu_pio_ext.sv
// Avalon-MM parallel I/O port with direction control and optional edge-capture interrupt.
// Define EMBCPU_PIO_EXT_IRQ_EN to build the irq mask, edge capture and irq logic.
module embcpu_pio_ext
    import embcpu_pio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
    parameter logic [31:0] DIR_RESET   = 32'hFFFF_FFFF,
    parameter int          EDGE_TYPE   = EDGE_RISE,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_sync_in;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_rd;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;

    assign w_wr = chipselect && !write_n;
    assign w_wd = writedata[WIDTH-1:0];

    embcpu_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .sync_in    (w_sync_in),
        .edge_pulse (w_edge)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= RESET_VALUE[WIDTH-1:0];
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:   r_out <= w_wd;
                ADDR_SET:    r_out <= r_out | w_wd;
                ADDR_CLEAR:  r_out <= r_out & ~w_wd;
                ADDR_TOGGLE: r_out <= r_out ^ w_wd;
                default:     r_out <= r_out;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         r_dir <= DIR_RESET[WIDTH-1:0];
        else if (w_wr && address == ADDR_DIR) r_dir <= w_wd;
    end

`ifdef EMBCPU_PIO_EXT_IRQ_EN
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] w_clr;

    assign w_clr = (w_wr && address == ADDR_EDGE_CAP) ? w_wd : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                              r_mask <= '0;
        else if (w_wr && address == ADDR_IRQ_MASK) r_mask <= w_wd;
    end

    // Setting wins over a simultaneous clear so a fresh edge is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_cap <= '0;
        else          r_cap <= (r_cap & ~w_clr) | (w_edge & ~r_dir);
    end

    assign irq = |(r_cap & r_mask);
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rd = '0;
        case (address)
            ADDR_DATA:     w_rd = (r_out & r_dir) | (w_sync_in & ~r_dir);
            ADDR_DIR:      w_rd = r_dir;
`ifdef EMBCPU_PIO_EXT_IRQ_EN
            ADDR_IRQ_MASK: w_rd = r_mask;
            ADDR_EDGE_CAP: w_rd = r_cap;
`endif
            default:       w_rd = '0;
        endcase
    end

    assign readdata = 32'(w_rd);
    assign out_port = r_out;
    assign oe_port  = r_dir;

    logic w_unused_ok;
    assign w_unused_ok = ^{writedata, w_edge};

endmodule

// File: tb/tb_embcpu_pio_ext.sv
// Self-checking bench for embcpu_pio_ext (WIDTH=8, default parameters), directed plus random traffic.
module tb_embcpu_pio_ext;
    import embcpu_pio_pkg::*;

    localparam int S = 2;
`ifdef EMBCPU_PIO_EXT_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [7:0]  in_port = 8'd0;
    wire  [31:0] readdata;
    wire  [7:0]  out_port;
    wire  [7:0]  oe_port;
    wire         irq;

    embcpu_pio_ext dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe_port    (oe_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Reference state: registers as values, pins as a delay line of samples taken at each edge.
    logic [7:0] m_out, m_dir, m_mask, m_cap;
    logic [7:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        m_out  = 8'h00;
        m_dir  = 8'hFF;
        m_mask = 8'h00;
        m_cap  = 8'h00;
        q = {};
        repeat (S + 1) q.push_back(8'h00);
    endtask

    function automatic logic [7:0] m_sync();
        return q[q.size() - S];
    endfunction

    function automatic logic [7:0] m_hist();
        return q[q.size() - S - 1];
    endfunction

    task automatic mdl_edge(input bit wr, input logic [2:0] a, input logic [31:0] d, input logic [7:0] pin);
        logic [7:0] wd, rise, clr;
        wd   = d[7:0];
        rise = m_sync() & ~m_hist();
        if (IRQ_EN) begin
            clr   = (wr && a == ADDR_EDGE_CAP) ? wd : 8'h00;
            m_cap = (m_cap & ~clr) | (rise & ~m_dir);
            if (wr && a == ADDR_IRQ_MASK) m_mask = wd;
        end
        if (wr) begin
            case (a)
                ADDR_DATA:   m_out = wd;
                ADDR_DIR:    m_dir = wd;
                ADDR_SET:    m_out = m_out | wd;
                ADDR_CLEAR:  m_out = m_out & ~wd;
                ADDR_TOGGLE: m_out = m_out ^ wd;
                default:     ;
            endcase
        end
        q.push_back(pin);
        if (q.size() > 8) void'(q.pop_front());
    endtask

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        case (a)
            ADDR_DATA:     return {24'd0, (m_out & m_dir) | (m_sync() & ~m_dir)};
            ADDR_DIR:      return {24'd0, m_dir};
            ADDR_IRQ_MASK: return IRQ_EN ? {24'd0, m_mask} : 32'd0;
            ADDR_EDGE_CAP: return IRQ_EN ? {24'd0, m_cap} : 32'd0;
            default:       return 32'd0;
        endcase
    endfunction

    task automatic check_all(input logic [2:0] rd_a);
        address = rd_a;
        #1;
        chk($sformatf("rd%0d", rd_a), readdata, exp_rd(rd_a));
        chk("out_port", {24'd0, out_port}, {24'd0, m_out});
        chk("oe_port", {24'd0, oe_port}, {24'd0, m_dir});
        chk("irq", {31'd0, irq}, IRQ_EN ? {31'd0, |(m_cap & m_mask)} : 32'd0);
    endtask

    task automatic cycle(input bit wr, input logic [2:0] a, input logic [31:0] d,
                         input logic [7:0] pin, input logic [2:0] rd_a);
        chipselect = wr;
        write_n    = !wr;
        address    = a;
        writedata  = d;
        in_port    = pin;
        @(posedge clk);
        mdl_edge(wr, a, d, pin);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        check_all(rd_a);
    endtask

    initial begin
        logic [7:0] pin;
        mdl_reset();
        repeat (3) @(negedge clk);
        check_all(ADDR_DATA);
        check_all(ADDR_IRQ_MASK);
        check_all(ADDR_EDGE_CAP);
        @(negedge clk);
        reset_n = 1'b1;

        cycle(1, ADDR_DATA, 32'hA5, 8'h00, ADDR_DATA);
        chk("a5_out", {24'd0, out_port}, 32'hA5);
        chk("a5_rd", readdata, 32'hA5);

        cycle(1, ADDR_SET, 32'h0F, 8'h00, ADDR_DATA);
        chk("outset", {24'd0, out_port}, 32'hAF);
        cycle(1, ADDR_CLEAR, 32'h81, 8'h00, ADDR_DATA);
        chk("outclear", {24'd0, out_port}, 32'h2E);
        cycle(1, ADDR_TOGGLE, 32'hFF, 8'h00, ADDR_DATA);
        chk("outtoggle", {24'd0, out_port}, 32'hD1);

        // Input sync latency and capture timing.
        cycle(1, ADDR_DIR, 32'h00, 8'h00, ADDR_DATA);
        cycle(0, ADDR_DATA, 32'h0, 8'h00, ADDR_DATA);
        cycle(0, ADDR_DATA, 32'h0, 8'h00, ADDR_DATA);
        cycle(0, ADDR_DATA, 32'h0, 8'h01, ADDR_DATA);
        chk("sync_1edge", readdata, 32'h00);
        cycle(0, ADDR_DATA, 32'h0, 8'h01, ADDR_DATA);
        chk("sync_2edge", readdata, 32'h01);
        cycle(0, ADDR_DATA, 32'h0, 8'h01, ADDR_EDGE_CAP);
        chk("cap_3edge", readdata, {31'd0, IRQ_EN});
        cycle(1, ADDR_IRQ_MASK, 32'h01, 8'h01, ADDR_EDGE_CAP);
        chk("irq_on", {31'd0, irq}, {31'd0, IRQ_EN});
        cycle(1, ADDR_EDGE_CAP, 32'h01, 8'h01, ADDR_EDGE_CAP);
        chk("irq_w1c", {31'd0, irq}, 32'd0);

        // Clear aligned with a new rising edge on the same bit.
        repeat (3) cycle(0, ADDR_DATA, 32'h0, 8'h00, ADDR_DATA);
        cycle(0, ADDR_DATA, 32'h0, 8'h01, ADDR_EDGE_CAP);
        cycle(0, ADDR_DATA, 32'h0, 8'h00, ADDR_EDGE_CAP);
        cycle(0, ADDR_DATA, 32'h0, 8'h01, ADDR_EDGE_CAP);
        chk("cap_before_race", readdata, {31'd0, IRQ_EN});
        cycle(0, ADDR_DATA, 32'h0, 8'h01, ADDR_EDGE_CAP);
        cycle(1, ADDR_EDGE_CAP, 32'h01, 8'h01, ADDR_EDGE_CAP);
        chk("w1c_race", readdata, {31'd0, IRQ_EN});
        cycle(1, ADDR_EDGE_CAP, 32'hFF, 8'h01, ADDR_EDGE_CAP);

        // Mixed direction: output bits never capture.
        cycle(1, ADDR_DIR, 32'h0F, 8'h3C, ADDR_DATA);
        cycle(1, ADDR_DATA, 32'h55, 8'h3C, ADDR_DATA);
        repeat (3) cycle(0, ADDR_DATA, 32'h0, 8'h3C, ADDR_DATA);
        cycle(1, ADDR_EDGE_CAP, 32'hFF, 8'h3C, ADDR_DATA);
        chk("mixed_rd", readdata, 32'h35);
        for (int i = 0; i < 8; i++) begin
            pin = 8'h30 | 8'($urandom_range(0, 15));
            cycle(0, ADDR_DATA, 32'h0, pin, ADDR_EDGE_CAP);
            chk("out_bits_nocap", readdata & 32'h0F, 32'h00);
        end

        // Mask/capture registers behaviour in this build.
        cycle(1, ADDR_IRQ_MASK, 32'hFF, 8'h3C, ADDR_IRQ_MASK);
        chk("mask_rd", readdata, IRQ_EN ? 32'hFF : 32'h00);
        cycle(1, ADDR_EDGE_CAP, 32'hFF, 8'h3C, ADDR_EDGE_CAP);
        chk("cap_rd_clr", readdata, 32'h00);
        cycle(1, ADDR_DIR, 32'h00, 8'h3C, ADDR_DATA);
        for (int i = 0; i < 12; i++) cycle(0, ADDR_DATA, 32'h0, 8'($urandom), ADDR_EDGE_CAP);

        // Random traffic.
        pin = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
            cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, pin,
                  3'($urandom_range(0, 7)));
        end

        // Asynchronous reset in the middle of a write.
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_DATA;
        writedata  = 32'h5A;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_out", {24'd0, out_port}, 32'h00);
        chk("async_oe", {24'd0, oe_port}, 32'hFF);
        chk("async_irq", {31'd0, irq}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset_n    = 1'b1;
        mdl_reset();
        check_all(ADDR_DATA);
        check_all(ADDR_EDGE_CAP);
        cycle(0, ADDR_DATA, 32'h0, 8'h00, ADDR_DATA);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
